// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: command owner and FSM state.
package mem_port_arbiter_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data has priority,
// bounded by a streak counter so a waiting fetch is served after MAX_D_STREAK data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_kill,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e          r_state, w_state_nxt;
    arb_owner_e          r_owner;
    logic                r_mem_req;
    logic                r_we;
    logic [BE_W-1:0]     r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STREAK_W-1:0] r_streak;
    logic                r_drop;
    logic                r_i_rvalid;
    logic [DATA_W-1:0]   r_i_rdata;
    logic                r_d_done;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_accept;
    logic w_complete;
    logic w_pick_i;
    logic w_i_gnt;
    logic w_d_gnt;

    // Fetch overrides data only once the data streak has hit its limit.
    assign w_pick_i = i_req && (!d_req || (r_streak == STREAK_MAX));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_accept = i_req || d_req;
            end
            ARB_BUSY: begin
                w_complete = mem_ack;
                w_accept   = mem_ack && (i_req || d_req);
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
        if (w_accept) begin
            w_state_nxt = ARB_BUSY;
        end else if (w_complete) begin
            w_state_nxt = ARB_IDLE;
        end
    end

    assign w_i_gnt = rst_n && w_accept && w_pick_i;
    assign w_d_gnt = rst_n && w_accept && !w_pick_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_mem_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= (w_state_nxt == ARB_BUSY);
        end
    end

    // Command register; fetches are always full-word reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_i_gnt) begin
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_be    <= '1;
            r_addr  <= i_addr;
            r_wdata <= '0;
        end else if (w_d_gnt) begin
            r_owner <= OWN_D;
            r_we    <= d_we;
            r_be    <= d_be;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (w_i_gnt) begin
            r_streak <= '0;
        end else if (w_d_gnt && i_req && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    // A kill arriving while the fetch is outstanding is remembered until its ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (w_complete && (r_owner == OWN_I)) begin
            r_drop <= 1'b0;
        end else if ((r_state == ARB_BUSY) && (r_owner == OWN_I) && i_kill) begin
            r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_done   <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_done   <= 1'b0;
            if (w_complete) begin
                if (r_owner == OWN_I) begin
                    if (!(r_drop || i_kill)) begin
                        r_i_rvalid <= 1'b1;
                        r_i_rdata  <= mem_rdata;
                    end
                end else begin
                    r_d_done <= 1'b1;
                    if (!r_we) begin
                        r_d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign i_gnt     = w_i_gnt;
    assign d_gnt     = w_d_gnt;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requesters and a variable-latency memory are
// driven at random and every cycle is scored against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0, i_kill = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [BW-1:0] d_be = '0;
    logic          i_gnt, i_rvalid, d_gnt, d_done, mem_req, mem_we;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus knobs
    int  p_i = 50, p_d = 50, p_kill = 0, minw = 0, maxw = 0, d_budget = -1;
    bit  hold = 1'b0, fix_i = 1'b0, fix_store = 1'b0;
    bit  i_seen = 1'b0, d_seen = 1'b0;
    int  wcnt = -1;
    bit  rec = 1'b0;
    int  n_rec = 0;
    logic [9:0] order = '0;
    int  cnt_iv = 0, cnt_dd = 0, cnt_mreq = 0;

    // reference model: in-flight command, streak, pending kill, expected completion
    bit            m_busy = 0, m_own_i = 0, m_we = 0, m_drop = 0;
    logic [BW-1:0] m_be = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_streak = 0;
    bit            e_iv = 0, e_dd = 0;
    logic [DW-1:0] e_ird = '0, e_drd = '0;
    bit            comp, acc, want_i, eig, edg;

    always @(posedge clk) begin
        #1;
        if (i_seen || !i_req) begin
            i_req  = hold || ($urandom_range(99) < p_i);
            i_addr = fix_i ? 32'h100 : ($urandom & ~32'h3);
        end else if (!hold && $urandom_range(99) < 3) begin
            i_req = 1'b0;
        end
        if (d_seen || !d_req) begin
            if (d_budget == 0) begin
                d_req = 1'b0;
            end else begin
                d_req = hold || ($urandom_range(99) < p_d);
                if (d_req && d_budget > 0) d_budget--;
            end
            if (fix_store) begin
                d_we = 1'b1; d_addr = 32'hFFFF_FFF0; d_wdata = 32'hA; d_be = 4'hF;
            end else begin
                d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
                d_be = 4'($urandom);
            end
        end else if (!hold && $urandom_range(99) < 3) begin
            d_req = 1'b0;
        end
        i_seen = 1'b0;
        d_seen = 1'b0;
        i_kill = ($urandom_range(99) < p_kill);
        if (mem_req && wcnt < 0) wcnt = $urandom_range(maxw, minw);
        mem_ack   = mem_req && (wcnt == 0);
        mem_rdata = $urandom;
    end

    always @(negedge clk) begin
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            if (m_own_i) chk("mem_we_fetch", mem_we, 0);
            else         chk("mem_cmd_data", {mem_we, mem_be, mem_wdata}, {m_we, m_be, m_wdata});
        end
        chk("i_rvalid", i_rvalid, e_iv);
        chk("i_rdata", i_rdata, e_ird);
        chk("d_done", d_done, e_dd);
        chk("d_rdata", d_rdata, e_drd);
        cnt_iv   += int'(i_rvalid);
        cnt_dd   += int'(d_done);
        cnt_mreq += int'(mem_req);

        comp   = m_busy && mem_ack;
        acc    = (!m_busy || mem_ack) && (i_req || d_req);
        want_i = i_req && (!d_req || m_streak == MAXS);
        eig    = rst_n && acc && want_i;
        edg    = rst_n && acc && !want_i;
        chk("i_gnt", i_gnt, eig);
        chk("d_gnt", d_gnt, edg);
        i_seen = i_gnt;
        d_seen = d_gnt;
        if (rec && (i_gnt || d_gnt) && n_rec < 10) begin
            order[n_rec] = i_gnt;
            n_rec++;
        end

        e_iv = 0;
        e_dd = 0;
        if (!rst_n) begin
            m_busy = 0; m_own_i = 0; m_we = 0; m_drop = 0; m_be = '0; m_addr = '0;
            m_wdata = '0; m_streak = 0; e_ird = '0; e_drd = '0;
            wcnt = -1;
        end else begin
            if (comp) begin
                if (m_own_i) begin
                    if (!(m_drop || i_kill)) begin
                        e_iv = 1; e_ird = mem_rdata;
                    end
                    m_drop = 0;
                end else begin
                    e_dd = 1;
                    if (!m_we) e_drd = mem_rdata;
                end
            end else if (m_busy && m_own_i && i_kill) begin
                m_drop = 1;
            end
            if (eig || edg) begin
                m_busy  = 1;
                m_own_i = eig;
                if (eig) begin
                    m_addr = i_addr; m_we = 0; m_streak = 0;
                end else begin
                    m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
                    if (i_req && m_streak < MAXS) m_streak++;
                end
            end else if (comp) begin
                m_busy = 0;
            end
            if (mem_ack) wcnt = -1;
            else if (mem_req && wcnt > 0) wcnt--;
        end
    end

    logic [DW-1:0] saved_drd;
    logic [9:0]    exp_order;
    bit            found;

    initial begin
        // reset held with both requests pending
        hold = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem", {mem_req, mem_we, mem_be, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_valid", {i_rvalid, d_done, i_gnt, d_gnt}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        rec = 1'b1;
        n_rec = 0;
        @(posedge clk); #2 rst_n = 1'b1;

        // both held continuously, zero-wait memory: fetch every fifth grant
        for (int k = 0; k < 200 && n_rec < 10; k++) @(negedge clk);
        #1;
        chk("grant_count", n_rec, 10);
        chk("first_gnt_is_d", order[0], 0);
        exp_order = 10'b10_0001_0000;
        chk("starve_order", order, exp_order);
        rec  = 1'b0;
        hold = 1'b0;

        // continuous zero-wait fetch to 0x100: one return per cycle
        p_d = 0; p_i = 100; fix_i = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk); #1 cnt_iv = 0;
        repeat (20) @(negedge clk);
        #1 chk("fetch_tput", cnt_iv, 20);
        fix_i = 1'b0;

        // single store with two wait states
        p_i = 0; p_d = 0;
        repeat (15) @(posedge clk);
        @(negedge clk); #1;
        saved_drd = d_rdata;
        cnt_dd = 0; cnt_mreq = 0;
        minw = 2; maxw = 2; fix_store = 1'b1; d_budget = 1; p_d = 100;
        repeat (15) @(negedge clk);
        #1;
        chk("store_done_once", cnt_dd, 1);
        chk("store_held", cnt_mreq, 3);
        chk("store_rdata_kept", d_rdata, saved_drd);
        fix_store = 1'b0; d_budget = -1;

        // fetches with delayed acks and kill pulses
        p_i = 100; p_d = 0; minw = 0; maxw = 3; p_kill = 15;
        repeat (300) @(posedge clk);

        // mixed random traffic
        p_i = 50; p_d = 50; p_kill = 10;
        repeat (2000) @(posedge clk);

        // reset while a command waits for its ack
        minw = 1; maxw = 3;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk); #2;
            if (mem_req && !mem_ack) found = 1'b1;
        end
        chk("found_busy", found, 1);
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_no_done", {i_rvalid, d_done}, 0);
        repeat (300) @(posedge clk);

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
